// File: rtl/mmio_data_memory.sv
// Word-addressed data RAM with an MMIO window: buffered keyboard FIFO,
// keyboard status/control word and a latched output port.
module mmio_data_memory #(
    parameter int          DATA_W        = 32,
    parameter int          ADDR_W        = 14,
    parameter int          KEY_W         = 8,
    parameter int          FIFO_DEPTH    = 8,
    parameter logic [31:0] KBD_DATA_ADDR = 32'h0000_FFFC,
    parameter logic [31:0] KBD_STAT_ADDR = 32'h0000_FFF8,
    parameter logic [31:0] OUT_ADDR      = 32'h0000_FFF4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       addr,
    input  logic [DATA_W-1:0] WD,
    input  logic              MemWrite,
    input  logic              MemRead,
    input  logic              sample,
    input  logic [KEY_W-1:0]  key_reg,
    output logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] out_port
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    logic              hit_kdata, hit_kstat, hit_out, hit_mmio;
    logic [ADDR_W-1:0] ram_idx;

    logic [DATA_W-1:0] ram_q [0:(1<<ADDR_W)-1];
    logic [KEY_W-1:0]  fifo_q [0:FIFO_DEPTH-1];

    logic              sync1_q, sync2_q, prev_q;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    logic [DATA_W-1:0] out_port_q, out_port_d;

    logic key_evt, fifo_full, pop, push_ok, push_drop, stat_wr;
    logic [DATA_W-1:0] rd_data;

    assign hit_kdata = (addr == KBD_DATA_ADDR);
    assign hit_kstat = (addr == KBD_STAT_ADDR);
    assign hit_out   = (addr == OUT_ADDR);
    assign hit_mmio  = hit_kdata | hit_kstat | hit_out;
    assign ram_idx   = addr[ADDR_W+1:2];

    // RAM is deliberately outside reset so its contents survive a reset.
    always_ff @(posedge clk) begin
        if (MemWrite && !hit_mmio) begin
            ram_q[ram_idx] <= WD;
        end
    end

    // sample is asynchronous; only the synchronised copy is compared to prev.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= sample;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign key_evt   = sync2_q ^ prev_q;
    assign fifo_full = (count_q == FULL_CNT);
    assign pop       = MemRead && !MemWrite && hit_kdata && (count_q != '0);
    // A pop on the same edge frees the slot, so a push into a full FIFO is kept.
    assign push_ok   = key_evt && (!fifo_full || pop);
    assign push_drop = key_evt && fifo_full && !pop;
    assign stat_wr   = MemWrite && hit_kstat;

    always_comb begin
        rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
        wr_ptr_d   = wr_ptr_q + PTR_W'(push_ok);
        count_d    = count_q + CNT_W'(push_ok) - CNT_W'(pop);
        overflow_d = overflow_q;
        if (push_drop) begin
            overflow_d = 1'b1;
        end else if (stat_wr) begin
            overflow_d = 1'b0;
        end
        out_port_d = out_port_q;
        if (MemWrite && hit_out) begin
            out_port_d = WD;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            out_port_q <= '0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            out_port_q <= out_port_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= key_reg;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit_kdata) begin
            if (count_q != '0) begin
                rd_data = {{(DATA_W-KEY_W){1'b0}}, fifo_q[rd_ptr_q]};
            end
        end else if (hit_kstat) begin
            rd_data = {overflow_q, {(DATA_W-1-CNT_W){1'b0}}, count_q};
        end else if (hit_out) begin
            rd_data = out_port_q;
        end else begin
            rd_data = ram_q[ram_idx];
        end
    end

    assign RD       = rd_data;
    assign out_port = out_port_q;

endmodule

// File: tb/tb_mmio_data_memory.sv
// Randomised bench for mmio_data_memory against a queue/array reference model.
module tb_mmio_data_memory;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 14;
    localparam int KEY_W  = 8;
    localparam int DEPTH  = 8;
    localparam logic [31:0] KD = 32'h0000_FFFC;
    localparam logic [31:0] KS = 32'h0000_FFF8;
    localparam logic [31:0] OA = 32'h0000_FFF4;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [31:0]       addr = '0;
    logic [DATA_W-1:0] WD = '0;
    logic              MemWrite = 1'b0;
    logic              MemRead = 1'b0;
    logic              sample = 1'b0;
    logic [KEY_W-1:0]  key_reg = '0;
    logic [DATA_W-1:0] RD;
    logic [DATA_W-1:0] out_port;

    int n_checks = 0;
    int n_errors = 0;

    // reference model
    logic [KEY_W-1:0]  exp_q[$];
    bit                ovf_m = 1'b0;
    logic [DATA_W-1:0] out_m = '0;
    logic [DATA_W-1:0] ram_m [int];

    mmio_data_memory #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .KEY_W(KEY_W), .FIFO_DEPTH(DEPTH),
        .KBD_DATA_ADDR(KD), .KBD_STAT_ADDR(KS), .OUT_ADDR(OA)
    ) dut (
        .clk(clk), .reset(reset), .addr(addr), .WD(WD),
        .MemWrite(MemWrite), .MemRead(MemRead), .sample(sample),
        .key_reg(key_reg), .RD(RD), .out_port(out_port)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) & ((32'd1 << ADDR_W) - 1));
    endfunction

    function automatic logic [31:0] status_m();
        return {ovf_m, 31'(exp_q.size())};
    endfunction

    function automatic logic [31:0] head_m();
        if (exp_q.size() == 0) return 32'd0;
        return 32'(exp_q[0]);
    endfunction

    // All driver tasks start and end just after a falling edge.
    task automatic write_word(input logic [31:0] a, input logic [31:0] d);
        addr = a; WD = d; MemWrite = 1'b1; MemRead = 1'b0;
        @(posedge clk);
        @(negedge clk);
        MemWrite = 1'b0;
        if (a == OA) out_m = d;
        else if (a == KS) ovf_m = 1'b0;
        else if (a != KD) ram_m[idx_of(a)] = d;
    endtask

    task automatic check_read(input string tag, input logic [31:0] a);
        logic [31:0] exp;
        addr = a; MemRead = 1'b0; MemWrite = 1'b0;
        #1;
        if (a == KD) exp = head_m();
        else if (a == KS) exp = status_m();
        else if (a == OA) exp = out_m;
        else exp = ram_m[idx_of(a)];
        check_eq(tag, RD, exp);
    endtask

    task automatic pop_key(input string tag);
        addr = KD; MemWrite = 1'b0; MemRead = 1'b1;
        #1;
        check_eq(tag, RD, head_m());
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        if (exp_q.size() > 0) void'(exp_q.pop_front());
    endtask

    // A toggle is counted by the third rising edge after it.
    task automatic push_key(input logic [KEY_W-1:0] k);
        key_reg = k;
        sample  = ~sample;
        repeat (3) @(posedge clk);
        @(negedge clk);
        if (exp_q.size() < DEPTH) exp_q.push_back(k);
        else ovf_m = 1'b1;
    endtask

    function automatic logic [31:0] pool_addr(input int i);
        logic [31:0] a;
        a = (32'($urandom_range(0, 16'hFFFF)) << 16) | (32'(32'h40 + i) << 2) | 32'($urandom_range(0, 3));
        return a;
    endfunction

    initial begin
        logic [KEY_W-1:0] k;
        logic [31:0] a;

        repeat (3) @(negedge clk);
        addr = KS; #1;
        check_eq("rst_status", RD, 32'd0);
        check_eq("rst_out_port", out_port, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check_read("rst_kdata", KD);

        // RAM and aliasing
        write_word(32'h40, 32'hDEAD_BEEF);
        check_read("ram_40", 32'h40);
        check_read("ram_41", 32'h41);
        write_word(32'h0001_FFF4, 32'hCAFE_F00D);
        write_word(OA, 32'h0000_5A5A);
        check_eq("out_port_wr", out_port, out_m);
        check_read("ram_3ffd_kept", 32'h0001_FFF4);
        check_read("out_rd", OA);

        // basic keys
        push_key(8'h41); push_key(8'h42); push_key(8'h43);
        check_read("stat_3", KS);
        for (int i = 0; i < 4; i++) pop_key("pop_basic");
        check_read("stat_empty", KS);

        // overflow
        for (int i = 0; i < DEPTH + 1; i++) push_key(KEY_W'($urandom_range(1, 255)));
        check_read("stat_ovf", KS);
        write_word(KD, 32'hFFFF_FFFF);
        check_read("stat_kd_write_ignored", KS);
        for (int i = 0; i < DEPTH; i++) pop_key("pop_ovf");
        check_read("stat_ovf_drained", KS);
        write_word(KS, 32'd0);
        check_read("stat_ovf_clr", KS);

        // simultaneous push and pop while full
        for (int i = 0; i < DEPTH; i++) push_key(KEY_W'($urandom_range(1, 255)));
        k = 8'hA7;
        key_reg = k;
        sample = ~sample;
        repeat (2) @(posedge clk);
        @(negedge clk);
        addr = KD; MemRead = 1'b1;
        #1;
        check_eq("sim_head", RD, head_m());
        @(posedge clk);
        @(negedge clk);
        MemRead = 1'b0;
        void'(exp_q.pop_front());
        exp_q.push_back(k);
        check_read("stat_sim", KS);
        for (int i = 0; i < DEPTH; i++) pop_key("pop_sim");

        // reset mid-operation
        for (int i = 0; i < 5; i++) push_key(KEY_W'($urandom_range(1, 255)));
        write_word(OA, 32'h1234);
        addr = KS;
        #3;
        reset = 1'b1;
        sample = 1'b0;
        exp_q.delete(); ovf_m = 1'b0; out_m = '0;
        #1;
        check_eq("midrst_status", RD, status_m());
        check_eq("midrst_out_port", out_port, 32'd0);
        addr = KD; #1;
        check_eq("midrst_kdata", RD, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        check_read("midrst_ram", 32'h40);
        push_key(8'h55);
        check_read("post_rst_stat", KS);
        pop_key("post_rst_pop");

        // wrap-around
        for (int i = 0; i < 20; i++) begin
            push_key(KEY_W'($urandom_range(0, 255)));
            pop_key("wrap_pop");
        end
        check_read("wrap_stat", KS);

        // randomised mix
        for (int i = 0; i < 16; i++) write_word(pool_addr(i), $urandom());
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: write_word(pool_addr($urandom_range(0, 15)), $urandom());
                1: check_read("rnd_ram", pool_addr($urandom_range(0, 15)));
                2: push_key(KEY_W'($urandom_range(0, 255)));
                3: pop_key("rnd_pop");
                4: begin
                    write_word(OA, $urandom());
                    check_eq("rnd_out_port", out_port, out_m);
                end
                5: check_read("rnd_stat", KS);
                6: write_word(KS, $urandom());
                default: begin
                    a = KD;
                    write_word(a, $urandom());
                    check_read("rnd_kd_wr", KS);
                end
            endcase
        end
        check_read("final_stat", KS);
        check_read("final_out", OA);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL timeout got=0 exp=1");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
